vm_change_dispenser: RTL and testbench

Payout engine for the vending machine: takes a latched credit (dollars/cents, as reported by the vending controller) and pays it out as a stream of physical coins to the coin hopper, largest denomination first, over a valid/ack handshake. Used for refunds and for change after a purchase. Reports coins paid and any residue that cannot be paid.

---
 rtl/vm_change_dispenser_if.sv | 26 ++
 rtl/vm_change_dispenser.sv | 141 ++++++++++++++
 tb/tb_vm_change_dispenser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vm_change_dispenser_if.sv
// Coin payout handshake between the vending controller/hopper side and the change dispenser.
interface vm_change_dispenser_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [7:0]       dollars;
    logic [7:0]       cents;
    logic             refill;
    logic             coin_ack;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] coins_paid;
    logic [14:0]      shortfall;

    modport master (
        output start, dollars, cents, refill, coin_ack,
        input  coin_valid, coin_type, busy, done, coins_paid, shortfall
    );

    modport slave (
        input  start, dollars, cents, refill, coin_ack,
        output coin_valid, coin_type, busy, done, coins_paid, shortfall
    );
endinterface

// File: rtl/vm_change_dispenser.sv
// Greedy coin payout engine (dollar, quarter, dime, nickel) over a valid/ack handshake.
// Define VM_CHANGE_INVENTORY_EN to track a finite per-denomination coin stock.
module vm_change_dispenser #(
    parameter int unsigned INIT_COUNT = 8,
    parameter int unsigned CNT_W      = 8
) (
    input logic                  clk,
    input logic                  rst,
    vm_change_dispenser_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] PAY    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [14:0]      remaining_q, remaining_d;
    logic             coin_valid_q, coin_valid_d;
    logic [1:0]       coin_type_q, coin_type_d;
    logic [CNT_W-1:0] coins_paid_q, coins_paid_d;
    logic [14:0]      shortfall_q, shortfall_d;
    logic [14:0]      balance;
    logic             sel_found;
    logic [1:0]       sel_type;

`ifdef VM_CHANGE_INVENTORY_EN
    logic [CNT_W-1:0] stock_q [4];
    logic [CNT_W-1:0] stock_d [4];
`else
    logic unused_cfg;
    assign unused_cfg = bus.refill ^ (INIT_COUNT != 0);
`endif

    function automatic logic [14:0] coin_value(input logic [1:0] t);
        case (t)
            2'd0:    coin_value = 15'd100;
            2'd1:    coin_value = 15'd25;
            2'd2:    coin_value = 15'd10;
            default: coin_value = 15'd5;
        endcase
    endfunction

    // dollars*100 peaks at 25500, so 15 bits never overflow
    assign balance = 15'(bus.dollars) * 15'd100 + 15'(bus.cents);

    // Scan smallest to largest so the largest eligible denomination wins
    always_comb begin
        sel_found = 1'b0;
        sel_type  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
`ifdef VM_CHANGE_INVENTORY_EN
            if (remaining_q >= coin_value(2'(i)) && stock_q[i] != '0) begin
`else
            if (remaining_q >= coin_value(2'(i))) begin
`endif
                sel_found = 1'b1;
                sel_type  = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_type_d  = coin_type_q;
        coins_paid_d = coins_paid_q;
        shortfall_d  = shortfall_q;
`ifdef VM_CHANGE_INVENTORY_EN
        stock_d = stock_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d  = balance;
                    coins_paid_d = '0;
                    shortfall_d  = '0;
                    state_d      = SELECT;
                end
`ifdef VM_CHANGE_INVENTORY_EN
                if (bus.refill) begin
                    for (int i = 0; i < 4; i++) stock_d[i] = CNT_W'(INIT_COUNT);
                end
`endif
            end
            SELECT: begin
                if (sel_found) begin
                    coin_type_d  = sel_type;
                    coin_valid_d = 1'b1;
                    state_d      = PAY;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = DONE;
                end
            end
            PAY: begin
                if (bus.coin_ack) begin
                    remaining_d  = remaining_q - coin_value(coin_type_q);
                    if (coins_paid_q != {CNT_W{1'b1}}) coins_paid_d = coins_paid_q + CNT_W'(1);
`ifdef VM_CHANGE_INVENTORY_EN
                    stock_d[coin_type_q] = stock_q[coin_type_q] - CNT_W'(1);
`endif
                    coin_valid_d = 1'b0;
                    state_d      = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_valid_q <= 1'b0;
            coin_type_q  <= 2'd0;
            coins_paid_q <= '0;
            shortfall_q  <= '0;
`ifdef VM_CHANGE_INVENTORY_EN
            for (int i = 0; i < 4; i++) stock_q[i] <= CNT_W'(INIT_COUNT);
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            coins_paid_q <= coins_paid_d;
            shortfall_q  <= shortfall_d;
`ifdef VM_CHANGE_INVENTORY_EN
            for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
`endif
        end
    end

    assign bus.coin_valid = coin_valid_q;
    assign bus.coin_type  = coin_type_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.coins_paid = coins_paid_q;
    assign bus.shortfall  = shortfall_q;
endmodule

// File: tb/tb_vm_change_dispenser.sv
// Randomized bench for vm_change_dispenser against a greedy-arithmetic payout model.
module tb_vm_change_dispenser;
`ifdef VM_CHANGE_INVENTORY_EN
    localparam int InitCount = 1;
`else
    localparam int InitCount = 8;
`endif
    localparam int CntMax = 255;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   val [4] = '{100, 25, 10, 5};
`ifdef VM_CHANGE_INVENTORY_EN
    int   m_stock [4];
`endif

    vm_change_dispenser_if #(.CNT_W(8)) bus ();

    vm_change_dispenser #(
        .INIT_COUNT(InitCount),
        .CNT_W     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reload();
`ifdef VM_CHANGE_INVENTORY_EN
        for (int k = 0; k < 4; k++) m_stock[k] = InitCount;
`endif
    endtask

    task automatic do_refill();
        @(negedge clk);
        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        model_reload();
    endtask

    // Run one payout; hold_first withholds ack on the first coin for that many cycles.
    task automatic run_payout(input logic [7:0] d, input logic [7:0] c, input int ack_pct,
                              input int hold_first, input bit noise);
        int exp_q[$];
        int rem, n, cyc, held, exp_paid, exp_short;
        bit finished, prev_xfer, prev_valid, first_coin, ack, new_coin;
        logic [1:0] prev_type;
        rem = int'(d) * 100 + int'(c);
        for (int k = 0; k < 4; k++) begin
            n = rem / val[k];
`ifdef VM_CHANGE_INVENTORY_EN
            if (n > m_stock[k]) n = m_stock[k];
            m_stock[k] -= n;
`endif
            rem -= n * val[k];
            repeat (n) exp_q.push_back(k);
        end
        exp_paid  = (exp_q.size() > CntMax) ? CntMax : exp_q.size();
        exp_short = rem;

        @(negedge clk);
        bus.start = 1'b1; bus.dollars = d; bus.cents = c;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("busy_after_start", bus.busy, 1);
        check_eq("select_no_valid", bus.coin_valid, 0);
        @(negedge clk);
        if (exp_q.size() > 0) check_eq("first_valid", bus.coin_valid, 1);
        else                  check_eq("zero_done", bus.done, 1);

        cyc = 0; finished = 0; prev_xfer = 0; prev_valid = 0; first_coin = 1; held = 0;
        prev_type = 2'd0;
        while (!finished && cyc < 4000) begin
            if (bus.done) begin
                finished = 1;
                check_eq("coins_paid", bus.coins_paid, exp_paid);
                check_eq("shortfall", bus.shortfall, exp_short);
                check_eq("coins_left", exp_q.size(), 0);
                check_eq("done_no_valid", bus.coin_valid, 0);
                bus.start = 1'b0; bus.refill = 1'b0; bus.coin_ack = 1'b0;
            end else begin
                if (prev_xfer) check_eq("gap_cycle", bus.coin_valid, 0);
                else if (prev_valid) begin
                    check_eq("hold_valid", bus.coin_valid, 1);
                    check_eq("hold_type", bus.coin_type, prev_type);
                end
                new_coin = bus.coin_valid && !(prev_valid && !prev_xfer);
                if (new_coin) begin
                    if (exp_q.size() == 0) check_eq("extra_coin", bus.coin_valid, 0);
                    else                   check_eq("coin_type", bus.coin_type, exp_q[0]);
                end
                ack = ($urandom_range(99) < ack_pct);
                if (bus.coin_valid && first_coin && held < hold_first) begin
                    ack = 0;
                    held++;
                end
                bus.coin_ack = ack;
                prev_xfer = bus.coin_valid && ack;
                if (prev_xfer) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    first_coin = 0;
                end
                prev_valid = bus.coin_valid;
                prev_type  = bus.coin_type;
                if (noise) begin
                    bus.start   = 1'($urandom_range(1));
                    bus.refill  = 1'($urandom_range(1));
                    bus.dollars = 8'($urandom_range(255));
                    bus.cents   = 8'($urandom_range(255));
                end
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", finished, 1);
        @(negedge clk);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("done_single", bus.done, 0);
        check_eq("paid_hold", bus.coins_paid, exp_paid);
        check_eq("short_hold", bus.shortfall, exp_short);
    endtask

    task automatic reset_mid_payout();
        @(negedge clk);
        bus.start = 1'b1; bus.dollars = 8'd1; bus.cents = 8'd40; bus.coin_ack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10 && !bus.coin_valid; i++) @(negedge clk);
        check_eq("rst_pre_valid", bus.coin_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reload();
        check_eq("rst_valid", bus.coin_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_paid", bus.coins_paid, 0);
        check_eq("rst_done", bus.done, 0);
        @(negedge clk);
        check_eq("rst_no_done", bus.done, 0);
        check_eq("rst_still_idle", bus.busy, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.dollars = '0; bus.cents = '0; bus.refill = 1'b0;
        bus.coin_ack = 1'b0;
        model_reload();
        repeat (3) @(negedge clk);
        check_eq("reset_valid", bus.coin_valid, 0);
        check_eq("reset_type", bus.coin_type, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        check_eq("reset_paid", bus.coins_paid, 0);
        check_eq("reset_short", bus.shortfall, 0);
        rst = 1'b0;

`ifdef VM_CHANGE_INVENTORY_EN
        run_payout(8'd2, 8'd0, 100, 0, 0);
        run_payout(8'd1, 8'd0, 100, 0, 0);
        do_refill();
        run_payout(8'd1, 8'd0, 100, 0, 0);
        do_refill();
`endif
        run_payout(8'd1, 8'd40, 100, 0, 0);
        run_payout(8'd0, 8'd7, 100, 0, 0);
        run_payout(8'd0, 8'd30, 100, 5, 0);
        run_payout(8'd0, 8'd0, 100, 0, 1);
        reset_mid_payout();
        run_payout(8'd255, 8'd255, 100, 0, 0);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(2) == 0) do_refill();
            run_payout(8'($urandom_range(3)), 8'($urandom_range(255)),
                       25 + int'($urandom_range(75)), int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
